// File: rtl/stack_cpu.sv
// Stack-machine core: fetches from a synchronous ROM and keeps its operand stack in a synchronous RAM.
// Faults and HALT are sticky until reset.
module stack_cpu #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int STACK_DEPTH = 256,
   parameter int STACK_BASE  = 0
) (
   input  logic                             clock,
   input  logic                             reset,
   output logic [ADDR_W-1:0]                address_rom,
   input  logic [DATA_W-1:0]                q_rom,
   output logic [ADDR_W-1:0]                address_ram,
   input  logic [DATA_W-1:0]                q_ram,
   output logic                             wren_ram,
   output logic [DATA_W-1:0]                data_ram,
   output logic                             halted,
   output logic                             error,
   output logic [1:0]                       error_code,
   output logic [ADDR_W-1:0]                dbg_pc,
   output logic [$clog2(STACK_DEPTH+1)-1:0] dbg_sp,
   output logic [3:0]                       dbg_state
);
   localparam int SP_W = $clog2(STACK_DEPTH+1);

   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_OPWAIT  = 4'd2;
   localparam logic [3:0] S_OPERAND = 4'd3;
   localparam logic [3:0] S_RD_B    = 4'd4;
   localparam logic [3:0] S_RD_A    = 4'd5;
   localparam logic [3:0] S_EXEC    = 4'd6;
   localparam logic [3:0] S_WRITE   = 4'd7;
   localparam logic [3:0] S_HALTED  = 4'd8;
   localparam logic [3:0] S_ERROR   = 4'd15;

   localparam logic [DATA_W-1:0] OP_IMM  = DATA_W'(8'h01);
   localparam logic [DATA_W-1:0] OP_ADD  = DATA_W'(8'h02);
   localparam logic [DATA_W-1:0] OP_SUB  = DATA_W'(8'h03);
   localparam logic [DATA_W-1:0] OP_POP  = DATA_W'(8'h04);
   localparam logic [DATA_W-1:0] OP_JZ   = DATA_W'(8'h05);
   localparam logic [DATA_W-1:0] OP_JMP  = DATA_W'(8'h06);
   localparam logic [DATA_W-1:0] OP_HALT = DATA_W'(8'h07);
   localparam logic [DATA_W-1:0] OP_NOP  = DATA_W'(8'h18);

   localparam logic [1:0] E_ILLEGAL   = 2'd1;
   localparam logic [1:0] E_OVERFLOW  = 2'd2;
   localparam logic [1:0] E_UNDERFLOW = 2'd3;

   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(STACK_BASE);

   logic [ADDR_W-1:0] pc_r;
   logic [SP_W-1:0]   sp_r;
   logic [3:0]        state_r;
   logic [DATA_W-1:0] op_r;
   logic [DATA_W-1:0] b_r;
   logic [ADDR_W-1:0] addr_ram_r;
   logic [DATA_W-1:0] data_ram_r;
   logic              wren_r;
   logic              halted_r;
   logic              error_r;
   logic [1:0]        err_code_r;

   logic [ADDR_W-1:0] pc_inc_s;
   logic [ADDR_W-1:0] push_addr_s;
   logic [ADDR_W-1:0] tos_addr_s;
   logic [ADDR_W-1:0] nos_addr_s;
   logic              has1_s;
   logic              has2_s;
   logic              room_s;

   // Stack addresses wrap to ADDR_W bits along with the base offset.
   assign pc_inc_s    = pc_r + ADDR_W'(1'b1);
   assign push_addr_s = BASE_A + ADDR_W'(sp_r);
   assign tos_addr_s  = push_addr_s - ADDR_W'(1'b1);
   assign nos_addr_s  = push_addr_s - ADDR_W'(2'd2);
   assign has1_s      = (sp_r >= SP_W'(1'b1));
   assign has2_s      = (sp_r >= SP_W'(2'd2));
   assign room_s      = (sp_r <  SP_W'(STACK_DEPTH));

   assign address_rom = pc_r;
   assign address_ram = addr_ram_r;
   assign data_ram    = data_ram_r;
   assign wren_ram    = wren_r;
   assign halted      = halted_r;
   assign error       = error_r;
   assign error_code  = err_code_r;
   assign dbg_pc      = pc_r;
   assign dbg_sp      = sp_r;
   assign dbg_state   = state_r;

   // Sequencer: one state per ROM/RAM access slot.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_r       <= '0;
         sp_r       <= '0;
         state_r    <= S_FETCH;
         op_r       <= '0;
         b_r        <= '0;
         addr_ram_r <= '0;
         data_ram_r <= '0;
         wren_r     <= 1'b0;
         halted_r   <= 1'b0;
         error_r    <= 1'b0;
         err_code_r <= 2'd0;
      end else begin
         case (state_r)
            S_FETCH: state_r <= S_DECODE;
            S_DECODE: begin
               op_r <= q_rom;
               case (q_rom)
                  OP_NOP: begin
                     pc_r    <= pc_inc_s;
                     state_r <= S_FETCH;
                  end
                  OP_POP: begin
                     if (has1_s) begin
                        sp_r    <= sp_r - SP_W'(1'b1);
                        pc_r    <= pc_inc_s;
                        state_r <= S_FETCH;
                     end else begin
                        error_r    <= 1'b1;
                        err_code_r <= E_UNDERFLOW;
                        state_r    <= S_ERROR;
                     end
                  end
                  OP_HALT: begin
                     halted_r <= 1'b1;
                     state_r  <= S_HALTED;
                  end
                  OP_IMM: begin
                     if (room_s) begin
                        pc_r    <= pc_inc_s;
                        state_r <= S_OPWAIT;
                     end else begin
                        error_r    <= 1'b1;
                        err_code_r <= E_OVERFLOW;
                        state_r    <= S_ERROR;
                     end
                  end
                  OP_JMP: begin
                     pc_r    <= pc_inc_s;
                     state_r <= S_OPWAIT;
                  end
                  OP_JZ: begin
                     if (has1_s) begin
                        addr_ram_r <= tos_addr_s;
                        sp_r       <= sp_r - SP_W'(1'b1);
                        pc_r       <= pc_inc_s;
                        state_r    <= S_OPWAIT;
                     end else begin
                        error_r    <= 1'b1;
                        err_code_r <= E_UNDERFLOW;
                        state_r    <= S_ERROR;
                     end
                  end
                  OP_ADD, OP_SUB: begin
                     if (has2_s) begin
                        addr_ram_r <= tos_addr_s;
                        state_r    <= S_RD_B;
                     end else begin
                        error_r    <= 1'b1;
                        err_code_r <= E_UNDERFLOW;
                        state_r    <= S_ERROR;
                     end
                  end
                  default: begin
                     error_r    <= 1'b1;
                     err_code_r <= E_ILLEGAL;
                     state_r    <= S_ERROR;
                  end
               endcase
            end
            S_OPWAIT: state_r <= S_OPERAND;
            S_OPERAND: begin
               case (op_r)
                  OP_IMM: begin
                     addr_ram_r <= push_addr_s;
                     data_ram_r <= q_rom;
                     wren_r     <= 1'b1;
                     sp_r       <= sp_r + SP_W'(1'b1);
                     pc_r       <= pc_inc_s;
                     state_r    <= S_WRITE;
                  end
                  OP_JMP: begin
                     pc_r    <= q_rom[ADDR_W-1:0];
                     state_r <= S_FETCH;
                  end
                  OP_JZ: begin
                     // q_ram holds the value popped in DECODE.
                     pc_r    <= (q_ram == {DATA_W{1'b0}}) ? q_rom[ADDR_W-1:0] : pc_inc_s;
                     state_r <= S_FETCH;
                  end
                  default: begin
                     error_r    <= 1'b1;
                     err_code_r <= E_ILLEGAL;
                     state_r    <= S_ERROR;
                  end
               endcase
            end
            S_RD_B: begin
               addr_ram_r <= nos_addr_s;
               state_r    <= S_RD_A;
            end
            S_RD_A: begin
               b_r     <= q_ram;
               state_r <= S_EXEC;
            end
            S_EXEC: begin
               data_ram_r <= (op_r == OP_SUB) ? (q_ram - b_r) : (q_ram + b_r);
               addr_ram_r <= nos_addr_s;
               wren_r     <= 1'b1;
               sp_r       <= sp_r - SP_W'(1'b1);
               pc_r       <= pc_inc_s;
               state_r    <= S_WRITE;
            end
            S_WRITE: begin
               wren_r  <= 1'b0;
               state_r <= S_FETCH;
            end
            S_HALTED, S_ERROR: wren_r <= 1'b0;
            default: begin
               wren_r     <= 1'b0;
               error_r    <= 1'b1;
               err_code_r <= E_ILLEGAL;
               state_r    <= S_ERROR;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_stack_cpu.sv
// Self-checking bench for stack_cpu: table of small programs scored through an expected-result queue,
// plus hand sequences for stack overflow (depth-4 instance) and reset during a RAM write.
module tb_stack_cpu;
   localparam logic [15:0] IMM  = 16'h0001;
   localparam logic [15:0] ADD  = 16'h0002;
   localparam logic [15:0] SUB  = 16'h0003;
   localparam logic [15:0] POP  = 16'h0004;
   localparam logic [15:0] JZ   = 16'h0005;
   localparam logic [15:0] JMP  = 16'h0006;
   localparam logic [15:0] HALT = 16'h0007;
   localparam logic [15:0] NOP  = 16'h0018;
   localparam logic [15:0] BAD  = 16'h00FF;

   logic clock = 1'b0;
   logic reset = 1'b1;

   logic [15:0] addr_rom_m, q_rom_m, addr_ram_m, q_ram_m, data_m, pc_m;
   logic        wren_m, halted_m, error_m;
   logic [1:0]  code_m;
   logic [8:0]  sp_m;
   logic [3:0]  state_m;

   logic [15:0] addr_rom_s, q_rom_s, addr_ram_s, q_ram_s, data_s, pc_s;
   logic        wren_s, halted_s, error_s;
   logic [1:0]  code_s;
   logic [2:0]  sp_s;
   logic [3:0]  state_s;

   logic [15:0] rom   [0:255];
   logic [15:0] ram_m [0:255];
   logic [15:0] ram_s [0:255];

   int tests = 0;
   int fails = 0;
   int wr_m  = 0;

   stack_cpu #(.DATA_W(16), .ADDR_W(16), .STACK_DEPTH(256), .STACK_BASE(0)) u_main (
      .clock(clock), .reset(reset), .address_rom(addr_rom_m), .q_rom(q_rom_m),
      .address_ram(addr_ram_m), .q_ram(q_ram_m), .wren_ram(wren_m), .data_ram(data_m),
      .halted(halted_m), .error(error_m), .error_code(code_m), .dbg_pc(pc_m),
      .dbg_sp(sp_m), .dbg_state(state_m));

   stack_cpu #(.DATA_W(16), .ADDR_W(16), .STACK_DEPTH(4), .STACK_BASE(0)) u_small (
      .clock(clock), .reset(reset), .address_rom(addr_rom_s), .q_rom(q_rom_s),
      .address_ram(addr_ram_s), .q_ram(q_ram_s), .wren_ram(wren_s), .data_ram(data_s),
      .halted(halted_s), .error(error_s), .error_code(code_s), .dbg_pc(pc_s),
      .dbg_sp(sp_s), .dbg_state(state_s));

   always #5 clock = ~clock;

   always @(posedge clock) begin
      q_rom_m <= rom[addr_rom_m[7:0]];
      q_rom_s <= rom[addr_rom_s[7:0]];
   end

   always @(posedge clock) begin
      if (wren_m) ram_m[addr_ram_m[7:0]] <= data_m;
      q_ram_m <= ram_m[addr_ram_m[7:0]];
   end

   always @(posedge clock) begin
      if (wren_s) ram_s[addr_ram_s[7:0]] <= data_s;
      q_ram_s <= ram_s[addr_ram_s[7:0]];
   end

   always @(posedge clock) if (wren_m) wr_m <= wr_m + 1;

   typedef struct {
      string            name;
      logic [7:0][15:0] prog;
      logic             halted;
      logic             error;
      logic [1:0]       code;
      logic [3:0]       state;
      logic [15:0]      pc;
      int               sp;
      logic             chk_ram;
      logic [15:0]      ram0;
      int               pulses;
      int               cycles;
   } vec_t;

   vec_t vecs [10];
   vec_t sb [$];

   function automatic logic [7:0][15:0] p8(input logic [15:0] a0, a1, a2, a3, a4, a5, a6, a7);
      logic [7:0][15:0] r;
      r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
      r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic load_rom(input logic [15:0] w [], input int n);
      for (int i = 0; i < 256; i++) rom[i] = HALT;
      for (int i = 0; i < n; i++) rom[i] = w[i];
   endtask

   task automatic release_reset();
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic hold_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
   endtask

   initial begin
      int          cyc;
      int          w0;
      vec_t        e;
      logic [15:0] w [];

      vecs[0] = '{"add",   p8(IMM, 16'd5, IMM, 16'd7, ADD, HALT, HALT, HALT), 1'b1, 1'b0, 2'd0, 4'd8,  16'd5,  1, 1'b1, 16'd12,   3, 18};
      vecs[1] = '{"sub",   p8(IMM, 16'd3, IMM, 16'd5, SUB, HALT, HALT, HALT), 1'b1, 1'b0, 2'd0, 4'd8,  16'd5,  1, 1'b1, 16'hFFFE, 3, 18};
      vecs[2] = '{"wrap",  p8(IMM, 16'hFFFF, IMM, 16'd2, ADD, HALT, HALT, HALT), 1'b1, 1'b0, 2'd0, 4'd8, 16'd5, 1, 1'b1, 16'd1,  3, 18};
      vecs[3] = '{"jz_t",  p8(IMM, 16'd0, JZ, 16'h10, HALT, HALT, HALT, HALT), 1'b1, 1'b0, 2'd0, 4'd8, 16'h10, 0, 1'b1, 16'd0,   1, 11};
      vecs[4] = '{"jz_nt", p8(IMM, 16'd1, JZ, 16'h10, HALT, HALT, HALT, HALT), 1'b1, 1'b0, 2'd0, 4'd8, 16'd4,  0, 1'b1, 16'd1,   1, 11};
      vecs[5] = '{"nop_pop", p8(NOP, IMM, 16'd4, POP, HALT, HALT, HALT, HALT), 1'b1, 1'b0, 2'd0, 4'd8, 16'd4,  0, 1'b1, 16'd4,   1, 11};
      vecs[6] = '{"undf",  p8(IMM, 16'd9, ADD, HALT, HALT, HALT, HALT, HALT), 1'b0, 1'b1, 2'd3, 4'd15, 16'd2,  1, 1'b1, 16'd9,   1, 7};
      vecs[7] = '{"illeg", p8(BAD, HALT, HALT, HALT, HALT, HALT, HALT, HALT), 1'b0, 1'b1, 2'd1, 4'd15, 16'd0,  0, 1'b0, 16'd0,   0, 2};
      vecs[8] = '{"jmp",   p8(JMP, 16'd6, BAD, BAD, BAD, BAD, HALT, HALT),    1'b1, 1'b0, 2'd0, 4'd8,  16'd6,  0, 1'b0, 16'd0,   0, 6};
      vecs[9] = '{"pop_u", p8(POP, HALT, HALT, HALT, HALT, HALT, HALT, HALT), 1'b0, 1'b1, 2'd3, 4'd15, 16'd0,  0, 1'b0, 16'd0,   0, 2};

      // Reset state while reset is held from time zero.
      for (int i = 0; i < 256; i++) rom[i] = HALT;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_pc",    {16'd0, pc_m},       32'd0);
      chk("rst_sp",    {23'd0, sp_m},       32'd0);
      chk("rst_state", {28'd0, state_m},    32'd0);
      chk("rst_wren",  {31'd0, wren_m},     32'd0);
      chk("rst_aram",  {16'd0, addr_ram_m}, 32'd0);
      chk("rst_dram",  {16'd0, data_m},     32'd0);
      chk("rst_flags", {29'd0, halted_m, error_m, 1'b0} | {30'd0, code_m}, 32'd0);

      for (int v = 0; v < 10; v++) begin
         hold_reset();
         for (int i = 0; i < 256; i++) rom[i] = HALT;
         for (int i = 0; i < 8; i++) rom[i] = vecs[v].prog[i];
         w0 = wr_m;
         sb.push_back(vecs[v]);
         release_reset();
         cyc = 0;
         while (!(halted_m || error_m) && cyc < 100) begin
            @(posedge clock);
            #1;
            cyc++;
         end
         repeat (4) @(posedge clock);
         #1;
         e = sb.pop_front();
         chk({e.name, "_cycles"}, cyc,                 e.cycles);
         chk({e.name, "_halted"}, {31'd0, halted_m},   {31'd0, e.halted});
         chk({e.name, "_error"},  {31'd0, error_m},    {31'd0, e.error});
         chk({e.name, "_code"},   {30'd0, code_m},     {30'd0, e.code});
         chk({e.name, "_state"},  {28'd0, state_m},    {28'd0, e.state});
         chk({e.name, "_pc"},     {16'd0, pc_m},       {16'd0, e.pc});
         chk({e.name, "_sp"},     {23'd0, sp_m},       e.sp);
         chk({e.name, "_pulses"}, wr_m - w0,           e.pulses);
         chk({e.name, "_wren"},   {31'd0, wren_m},     32'd0);
         if (e.chk_ram) chk({e.name, "_ram0"}, {16'd0, ram_m[0]}, {16'd0, e.ram0});
      end

      // Overflow on the depth-4 instance; the deep instance runs the same program to completion.
      hold_reset();
      w = new[11];
      w = '{IMM, 16'd11, IMM, 16'd22, IMM, 16'd33, IMM, 16'd44, IMM, 16'd55, HALT};
      load_rom(w, 11);
      release_reset();
      cyc = 0;
      while (!(error_s && halted_m) && cyc < 200) begin
         @(posedge clock);
         #1;
         cyc++;
      end
      chk("ovf_timeout", {31'd0, cyc < 200}, 32'd1);
      chk("ovf_code",  {30'd0, code_s},  32'd2);
      chk("ovf_state", {28'd0, state_s}, 32'd15);
      chk("ovf_sp",    {29'd0, sp_s},    32'd4);
      chk("ovf_pc",    {16'd0, pc_s},    32'd8);
      chk("ovf_halt",  {31'd0, halted_s}, 32'd0);
      for (int i = 0; i < 4; i++) chk("ovf_ram", {16'd0, ram_s[i]}, 11 * (i + 1));
      chk("deep_sp",   {23'd0, sp_m},     32'd5);
      chk("deep_ram4", {16'd0, ram_m[4]}, 32'd55);
      chk("deep_pc",   {16'd0, pc_m},     32'd10);

      // Reset landing in the WRITE cycle of the first IMM must cancel the write.
      hold_reset();
      w = new[3];
      w = '{IMM, 16'h0ABC, HALT};
      load_rom(w, 3);
      release_reset();
      cyc = 0;
      while (!wren_m && cyc < 20) begin
         @(posedge clock);
         #1;
         cyc++;
      end
      chk("mw_seen",  {31'd0, wren_m}, 32'd1);
      chk("mw_state", {28'd0, state_m}, 32'd7);
      w0 = wr_m;
      reset = 1'b1;
      #1;
      chk("mw_wren",  {31'd0, wren_m}, 32'd0);
      chk("mw_pc",    {16'd0, pc_m},   32'd0);
      chk("mw_sp",    {23'd0, sp_m},   32'd0);
      chk("mw_st0",   {28'd0, state_m}, 32'd0);
      repeat (2) @(posedge clock);
      #1;
      chk("mw_lost",   {16'd0, ram_m[0]}, 32'd11);
      chk("mw_pulses", wr_m - w0, 0);
      release_reset();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/stack_cpu.md
Name: stack_cpu

Overview:
Parametrised stack-machine core that executes instructions from a synchronous ROM and keeps its operand stack in a synchronous RAM. It generalises the existing fetch/IMM/JMP/NOP core with configurable data, address and stack widths, arithmetic and conditional-branch opcodes, POP and HALT, stack overflow/underflow detection, sticky error codes, and an asynchronous reset. It sits between the program ROM and the data RAM and exposes debug taps for display.

Parameters:
DATA_W, 16, width of ROM words, RAM words and the arithmetic datapath.
ADDR_W, 16, width of ROM and RAM addresses and of pc; requires ADDR_W <= DATA_W.
STACK_DEPTH, 256, maximum number of stack entries.
STACK_BASE, 0, RAM address of stack slot 0.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
address_rom  out  ADDR_W  ROM address; equals pc.
q_rom  in  DATA_W  ROM data; 1-cycle read latency.
address_ram  out  ADDR_W  RAM address (registered).
q_ram  in  DATA_W  RAM read data; 1-cycle read latency.
wren_ram  out  1  RAM write enable (registered).
data_ram  out  DATA_W  RAM write data (registered).
halted  out  1  sticky; set by HALT.
error  out  1  sticky; set on a fault.
error_code  out  2  0 none, 1 illegal opcode, 2 overflow, 3 underflow.
dbg_pc  out  ADDR_W  current pc.
dbg_sp  out  $clog2(STACK_DEPTH+1)  current stack count.
dbg_state  out  4  state encoding.

Behaviour:
- Reset is asynchronous and active-high. On reset: pc=0, sp=0, address_ram=0, data_ram=0, wren_ram=0, halted=0, error=0, error_code=0, state=FETCH. A reset that arrives mid-write drops wren_ram immediately, and the write is lost.
- sp is the count of stacked entries. The top of stack (TOS) is at STACK_BASE+sp-1. RAM addresses are truncated to ADDR_W.
- The opcode is the full q_rom word, zero-extended. The encodings are NOP=0x18, IMM=0x01, ADD=0x02, SUB=0x03, POP=0x04, JZ=0x05, JMP=0x06, HALT=0x07. Any other value is illegal.
- State encoding: FETCH=0, DECODE=1, OPWAIT=2, OPERAND=3, RD_B=4, RD_A=5, EXEC=6, WRITE=7, HALTED=8, ERROR=15.
- FETCH: ROM samples pc; go to DECODE.
- DECODE (q_rom holds the opcode), by opcode:
  - NOP: pc+1, go to FETCH.
  - POP: needs sp>=1; sp-1, pc+1, go to FETCH.
  - HALT: halted=1, go to HALTED; pc is unchanged.
  - IMM: needs sp<STACK_DEPTH; pc+1, go to OPWAIT.
  - JMP: pc+1, go to OPWAIT.
  - JZ: needs sp>=1; address_ram=TOS address, sp-1, pc+1, go to OPWAIT.
  - ADD/SUB: needs sp>=2; address_ram=STACK_BASE+sp-1, go to RD_B.
  - Illegal opcode: error_code=1, go to ERROR.
  - A failed sp check sets error_code=2 (overflow) or 3 (underflow) and goes to ERROR. On any fault, sp, pc and RAM are unchanged.
- OPWAIT: ROM samples the operand address; go to OPERAND.
- OPERAND (q_rom holds the operand), by opcode:
  - IMM: address_ram=STACK_BASE+sp, data_ram=q_rom, wren_ram=1, sp+1, pc+1, go to WRITE.
  - JMP: pc=q_rom[ADDR_W-1:0], go to FETCH.
  - JZ: if q_ram==0 then pc=q_rom[ADDR_W-1:0], else pc+1; go to FETCH. The popped value is consumed either way.
- RD_B: address_ram=STACK_BASE+sp-2; go to RD_A.
- RD_A: latch b=q_ram (the TOS); go to EXEC.
- EXEC: a=q_ram. Set data_ram=a+b (ADD) or a-b (SUB), modulo 2^DATA_W with no carry or flags. Set address_ram=STACK_BASE+sp-2, wren_ram=1, sp-1, pc+1, go to WRITE.
- WRITE: wren_ram is high for exactly this one cycle; on exit wren_ram=0, go to FETCH.
- pc wraps modulo 2^ADDR_W.
- HALTED and ERROR are terminal until reset. In them wren_ram=0 and all registers hold.
- Cycle counts: NOP/POP/HALT 2, JMP/JZ 4, IMM 5, ADD/SUB 6.

Test Plan:
- ROM {0:IMM, 1:5, 2:IMM, 3:7, 4:ADD, 5:HALT} -> RAM[0]=12, sp=1, pc=5, halted=1 at cycle 18; wren_ram pulses exactly 3 times.
- IMM 3, IMM 5, SUB (DATA_W=16) -> RAM[0]=0xFFFE, sp=1.
- IMM 0, JZ 0x10 -> pc=0x10, sp=0. Separately, IMM 1, JZ 0x10 at address 2 -> pc=4, sp=0.
- IMM 9, ADD (sp=1) -> error=1, error_code=3, pc=2, sp=1, no further wren_ram pulses.
- STACK_DEPTH=4, five IMMs -> fifth gives error_code=2, sp=4, RAM[0..3] intact.
- ROM[0]=0x00FF -> error_code=1, dbg_state=15. Separately, reset asserted during WRITE -> wren_ram=0 before the next edge, pc=0, sp=0.
